// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR/flag inputs and datapath control outputs of the multi-cycle controller.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        ir_we;
  logic        pc_we;
  logic [2:0]  npc_sel;
  logic [1:0]  regdst;
  logic        alusrc;
  logic [2:0]  alu_ctr;
  logic [1:0]  ext_op;
  logic [1:0]  memtoreg;
  logic        regwrite;
  logic        memwrite;
  logic [3:0]  state;
  logic        instr_done;
  modport master (
    input  instr, zero,
    output ir_we, pc_we, npc_sel, regdst, alusrc, alu_ctr, ext_op, memtoreg,
           regwrite, memwrite, state, instr_done
  );
  modport slave (
    output instr, zero,
    input  ir_we, pc_we, npc_sel, regdst, alusrc, alu_ctr, ext_op, memtoreg,
           regwrite, memwrite, state, instr_done
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller stepping FETCH/DECODE/EXE/MEM/WB; only the last state writes PC/GPR/DM.
// Optional: CTRL_JAL_EN decodes jal (writes $31 with pc+4 in JUMP); otherwise opcode 000011 is a nop.
module mc_ctrl (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXE    = 4'd2,
    MEM_RD = 4'd3,
    MEM_WR = 4'd4,
    WB_ALU = 4'd5,
    WB_MEM = 4'd6,
    BRANCH = 4'd7,
    JUMP   = 4'd8
  } state_t;
  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_JR, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_BAD
  } op_t;
  state_t state_q, state_d;
  op_t op;
  logic [5:0] opc, fn;
  logic exe_src, alu_phase, pc_we;
  logic [2:0] exe_alu;
  logic [1:0] exe_ext;
  logic unused_ok;
  assign opc = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  // zero is consumed by npc directly; register fields feed the datapath, not the controller
  assign unused_ok = ^{bus.zero, bus.instr[25:6]};
  always_comb begin
    op = OP_BAD;
    case (opc)
      6'b000000: op = fn == 6'b100001 ? OP_ADDU : fn == 6'b100011 ? OP_SUBU : fn == 6'b001000 ? OP_JR : OP_BAD;
      6'b001101: op = OP_ORI;
      6'b001111: op = OP_LUI;
      6'b100011: op = OP_LW;
      6'b101011: op = OP_SW;
      6'b000100: op = OP_BEQ;
      6'b000010: op = OP_J;
`ifdef CTRL_JAL_EN
      6'b000011: op = OP_JAL;
`endif
      default:   op = OP_BAD;
    endcase
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = op == OP_BEQ ? BRANCH : op inside {OP_J, OP_JAL, OP_JR} ? JUMP : op == OP_BAD ? FETCH : EXE;
      EXE:    state_d = op == OP_LW ? MEM_RD : op == OP_SW ? MEM_WR : WB_ALU;
      MEM_RD: state_d = WB_MEM;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else state_q <= state_d;
  end
  // alu controls chosen in EXE are held through the memory and write-back states
  assign exe_src = op inside {OP_ORI, OP_LUI, OP_LW, OP_SW};
  assign exe_alu = op == OP_SUBU ? 3'b001 : op == OP_ORI ? 3'b010 : 3'b000;
  assign exe_ext = op == OP_LUI ? 2'b10 : op inside {OP_LW, OP_SW} ? 2'b01 : 2'b00;
  assign alu_phase = state_q inside {EXE, MEM_RD, MEM_WR, WB_ALU, WB_MEM};
  assign pc_we = state_q inside {MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP} || (state_q == DECODE && op == OP_BAD);
  always_comb begin
    bus.ir_we = state_q == FETCH;
    bus.pc_we = pc_we;
    bus.instr_done = pc_we;
    bus.state = state_q;
    bus.npc_sel = state_q == BRANCH ? 3'b001 : state_q != JUMP ? 3'b000 : op == OP_JR ? 3'b011 : 3'b010;
    bus.alusrc = (alu_phase && exe_src) || (state_q == JUMP && op == OP_JR);
    bus.alu_ctr = alu_phase ? exe_alu : state_q == BRANCH ? 3'b001 : 3'b000;
    bus.ext_op = alu_phase ? exe_ext : 2'b00;
    bus.regdst = state_q == WB_ALU && op inside {OP_ADDU, OP_SUBU} ? 2'b01 : 2'b00;
    bus.memtoreg = state_q == WB_MEM ? 2'b01 : 2'b00;
    bus.regwrite = state_q inside {WB_ALU, WB_MEM};
    bus.memwrite = state_q == MEM_WR;
`ifdef CTRL_JAL_EN
    if (state_q == JUMP && op == OP_JAL) begin
      bus.regdst = 2'b10;
      bus.memtoreg = 2'b10;
      bus.regwrite = 1'b1;
    end
`endif
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream checked per cycle against a per-instruction behavioural model.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  mc_ctrl_if bus();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] state;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] npc_sel;
    logic [1:0] regdst;
    logic       alusrc;
    logic [2:0] alu_ctr;
    logic [1:0] ext_op;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       instr_done;
  } out_t;
  out_t exp_q[$];
  out_t obs[8];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask
  function automatic out_t snap();
    out_t o;
    o.state = bus.state;
    o.ir_we = bus.ir_we;
    o.pc_we = bus.pc_we;
    o.npc_sel = bus.npc_sel;
    o.regdst = bus.regdst;
    o.alusrc = bus.alusrc;
    o.alu_ctr = bus.alu_ctr;
    o.ext_op = bus.ext_op;
    o.memtoreg = bus.memtoreg;
    o.regwrite = bus.regwrite;
    o.memwrite = bus.memwrite;
    o.instr_done = bus.instr_done;
    return o;
  endfunction
  // expected per-cycle outputs for one whole instruction, derived from its class and state path
  task automatic model(input logic [31:0] ins, output int n);
    logic [5:0] op, fn;
    string k;
    int path[$];
    logic src;
    logic [2:0] alu;
    logic [1:0] ext;
    out_t o;
    op = ins[31:26];
    fn = ins[5:0];
    k = "bad";
    if (op == 6'h00) begin
      if (fn == 6'h21) k = "addu";
      else if (fn == 6'h23) k = "subu";
      else if (fn == 6'h08) k = "jr";
    end
    else if (op == 6'h0d) k = "ori";
    else if (op == 6'h0f) k = "lui";
    else if (op == 6'h23) k = "lw";
    else if (op == 6'h2b) k = "sw";
    else if (op == 6'h04) k = "beq";
    else if (op == 6'h02) k = "j";
`ifdef CTRL_JAL_EN
    else if (op == 6'h03) k = "jal";
`endif
    if (k == "addu" || k == "subu" || k == "ori" || k == "lui") path = '{0, 1, 2, 5};
    else if (k == "lw") path = '{0, 1, 2, 3, 6};
    else if (k == "sw") path = '{0, 1, 2, 4};
    else if (k == "beq") path = '{0, 1, 7};
    else if (k == "j" || k == "jal" || k == "jr") path = '{0, 1, 8};
    else path = '{0, 1};
    src = (k == "ori" || k == "lui" || k == "lw" || k == "sw");
    alu = k == "subu" ? 3'd1 : k == "ori" ? 3'd2 : 3'd0;
    ext = k == "lui" ? 2'd2 : (k == "lw" || k == "sw") ? 2'd1 : 2'd0;
    n = path.size();
    foreach (path[i]) begin
      o = '0;
      o.state = 4'(path[i]);
      o.instr_done = (i == n - 1);
      if (path[i] == 0) o.ir_we = 1'b1;
      if (path[i] == 1 && k == "bad") o.pc_we = 1'b1;
      if (path[i] >= 2 && path[i] <= 6) begin
        o.alusrc = src;
        o.alu_ctr = alu;
        o.ext_op = ext;
      end
      if (path[i] == 4) begin o.memwrite = 1'b1; o.pc_we = 1'b1; end
      if (path[i] == 5) begin
        o.regwrite = 1'b1;
        o.pc_we = 1'b1;
        o.regdst = (k == "addu" || k == "subu") ? 2'd1 : 2'd0;
      end
      if (path[i] == 6) begin o.regwrite = 1'b1; o.memtoreg = 2'd1; o.pc_we = 1'b1; end
      if (path[i] == 7) begin o.alu_ctr = 3'd1; o.npc_sel = 3'd1; o.pc_we = 1'b1; end
      if (path[i] == 8) begin
        o.pc_we = 1'b1;
        o.npc_sel = k == "jr" ? 3'd3 : 3'd2;
        if (k == "jr") o.alusrc = 1'b1;
        if (k == "jal") begin o.regwrite = 1'b1; o.regdst = 2'd2; o.memtoreg = 2'd2; end
      end
      exp_q.push_back(o);
    end
  endtask
  always @(negedge clk) begin
    out_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("model cycle exp_state=%0d", e.state), 32'(snap()), 32'(e));
    end
  end
  // FETCH shows garbage on instr; IR value appears on the FETCH->DECODE edge
  task automatic run(input logic [31:0] ins, input int zmode, input int ncyc);
    int n;
    model(ins, n);
    if (ncyc > 0) n = ncyc;
    for (int i = 0; i < 8; i++) obs[i] = '0;
    bus.instr = $urandom;
    for (int c = 0; c < n; c++) begin
      bus.zero = zmode < 0 ? 1'($urandom % 2) : 1'(zmode);
      @(negedge clk);
      obs[c] = snap();
      @(posedge clk);
      #1;
      if (c == 0) bus.instr = ins;
    end
  endtask
  function automatic int done_len();
    for (int i = 0; i < 8; i++) if (obs[i].instr_done) return i + 1;
    return 0;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: return {6'h00, r[25:6], 6'h21};
      1: return {6'h00, r[25:6], 6'h23};
      2: return {6'h00, r[25:6], 6'h08};
      3: return {6'h0d, r[25:0]};
      4: return {6'h0f, r[25:0]};
      5: return {6'h23, r[25:0]};
      6: return {6'h2b, r[25:0]};
      7: return {6'h04, r[25:0]};
      8: return {6'h02, r[25:0]};
      9: return {6'h03, r[25:0]};
      10: return {6'h00, r[25:0]};
      default: return r;
    endcase
  endfunction
  initial begin
    bus.instr = 32'h0;
    bus.zero = 1'b0;
    #2;
    chk("reset outputs", 32'(snap()), 32'h0002_0000);
    @(posedge clk);
    #1;
    chk("reset held state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    run(32'h00221821, -1, 0);
    chk("addu states", {obs[0].state, obs[1].state, obs[2].state, obs[3].state}, 32'h0125);
    chk("addu wb regwrite/regdst/pc_we", {obs[3].regwrite, obs[3].regdst, obs[3].pc_we}, 32'b1011);
    chk("addu next state", 32'(bus.state), 32'd0);
    run(32'h8C040008, -1, 0);
    chk("lw length", 32'(done_len()), 32'd5);
    chk("lw wb memtoreg", 32'(obs[4].memtoreg), 32'd1);
    chk("lw exe ext_op/alusrc", {obs[2].ext_op, obs[2].alusrc}, 32'b011);
    for (int z = 1; z >= 0; z--) begin
      run(32'h10220003, z, 0);
      chk($sformatf("beq z=%0d branch npc/pc_we", z), {obs[2].state, obs[2].npc_sel, obs[2].pc_we}, {4'd7, 3'b001, 1'b1});
      chk($sformatf("beq z=%0d length", z), 32'(done_len()), 32'd3);
      chk($sformatf("beq z=%0d after", z), 32'(bus.state), 32'd0);
    end
    run(32'h0C000010, -1, 0);
`ifdef CTRL_JAL_EN
    chk("jal jump", {obs[2].state, obs[2].regdst, obs[2].memtoreg, obs[2].regwrite, obs[2].npc_sel},
        {4'd8, 2'b10, 2'b10, 1'b1, 3'b010});
`else
    chk("jal as nop length", 32'(done_len()), 32'd2);
    chk("jal as nop no write", {obs[0].regwrite, obs[1].regwrite, obs[1].pc_we}, 32'b001);
`endif
    run(32'hFC000000, -1, 0);
    chk("unknown decode pc_we/npc", {obs[1].state, obs[1].pc_we, obs[1].npc_sel}, {4'd1, 1'b1, 3'b000});
    chk("unknown length", 32'(done_len()), 32'd2);
    chk("unknown no writes", {obs[0].regwrite, obs[0].memwrite, obs[1].regwrite, obs[1].memwrite}, 32'd0);
    for (int i = 0; i < 150; i++) run(rand_instr(), -1, 0);
    run(32'h8C040008, -1, 3);
    chk("pre-reset in MEM_RD", 32'(bus.state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {bus.state, bus.regwrite, bus.ir_we, bus.pc_we}, {4'd0, 1'b0, 1'b1, 1'b0});
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("reset no wb state", {bus.state, bus.regwrite}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) run(rand_instr(), -1, 0);
    chk("model queue drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
